serial_transmitter: RTL and testbench
=====================================

# serial_transmitter

Parallel-in, serial-out framed transmitter that pairs with `ShiftRegisterSIPO` as the sending end of a single-wire link. It accepts a WIDTH-bit word over a valid/ready handshake and frames it as one start bit, WIDTH data bits and one stop bit. Bit order is selectable per word. Each bit is held for a programmable number of clocks. An `en_out` strobe is provided so a same-clock `ShiftRegisterSIPO` can capture the data bits directly.

## Interface
- `WIDTH`, default 8: data word width, ≥ 2.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit, ≥ 1.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `data`  in  WIDTH: word to transmit; sampled only at accept.
- `valid`  in  1: `data`/`left` are offered.
- `left`  in  1: bit order, sampled at accept. 1 = MSB first, 0 = LSB first; matches the receiver's `left`.
- `ready`  out  1: transmitter can accept a word this cycle.
- `serial`  out  1: line output; idles at 1.
- `busy`  out  1: frame in progress.
- `en_out`  out  1: one-cycle strobe in the last cycle of each data bit.
- `done`  out  1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- States:
  - IDLE: `serial`=1, `ready`=1.
  - START: `serial`=0.
  - DATA: `serial` = current bit.
  - STOP: `serial`=1.
- Counters:
  - `cyc_cnt`: counts 0..CLKS_PER_BIT-1 within each bit. Width is max(1, $clog2(CLKS_PER_BIT)).
  - `bit_cnt`: counts 0..WIDTH-1 across data bits.
- Accept occurs when `valid && ready` at a rising edge.
  - Load `data` into the internal shift register and latch `left`.
  - Clear both counters.
  - Go to START.
- A bit ends when `cyc_cnt == CLKS_PER_BIT-1`. At that point `cyc_cnt` wraps to 0 and:
  - START → DATA.
  - DATA with `bit_cnt == WIDTH-1` → STOP. Otherwise `bit_cnt`+1 and shift by one, toward MSB if `left` else toward LSB.
  - STOP → IDLE.
- Bit source: `serial` in DATA is the shift register MSB when `left`=1, the LSB when `left`=0.
- `en_out`=1 only in DATA during the bit-ending cycle, so exactly WIDTH pulses per frame.
- `done`=1 only in STOP during the bit-ending cycle.
- `ready` = (state == IDLE). `busy` = !ready.
- `valid` while busy is ignored; there is no queueing. Changes on `data`/`left` after accept have no effect.
- `serial`, `en_out` and `done` are registered, decoded from next-state.
- Reset values: state IDLE, counters 0, `serial`=1, `ready`=1, `busy`=0, `en_out`=0, `done`=0.

## Timing
- Frame length is (WIDTH+2)·CLKS_PER_BIT cycles. It starts the cycle after the accept edge and ends on the `done` cycle.
- `ready` rises the cycle after `done`. A word offered then is accepted at the next edge.
- Minimum gap between frames is 1 idle cycle at `serial`=1, so back-to-back throughput is one word per (WIDTH+2)·CLKS_PER_BIT+1 cycles.
- With CLKS_PER_BIT=1, every cycle is bit-ending: `en_out` is high for WIDTH consecutive cycles and `done` for the single STOP cycle.
- Reset mid-frame:
  - Outputs take their reset values immediately, without waiting for a clock edge.
  - The partial frame is abandoned.
  - The first edge after deassertion may accept a new word.
- Reset asserted at the same edge as an accept: reset wins and nothing is loaded.
- The receiver samples on edges where `en_out`=1. `serial` is stable for the whole bit, so the same-clock capture is hazard-free.

## Test plan
- Reset: assert `reset` mid-idle and mid-DATA → `serial`=1, `ready`=1, `busy`=0, `en_out`=0, `done`=0 with no clock edge. After deassert, `data`=8'h5A sends a clean frame.
- MSB-first, WIDTH=8, CLKS_PER_BIT=4:
  - Stimulus: `data`=8'hC1, `left`=1.
  - `serial` is 0×4, then bits 1,1,0,0,0,0,0,1 at 4 cycles each, then 1×4.
  - Eight `en_out` pulses.
  - `done` exactly 40 cycles after accept.
  - Loopback `ShiftRegisterSIPO` (en=`en_out`, left=1) ends with Q=8'hC1.
- LSB-first: `data`=8'hC1, `left`=0 → data bits 1,0,0,0,0,0,1,1. `ShiftRegisterSIPO` with left=0 ends with Q=8'hC1.
- Back-to-back: `valid` held high with 8'h12 then 8'h34 → `ready` low exactly 40 cycles per frame, one idle cycle between frames, both words received in order.
- Ignored inputs: during a frame, toggle `valid` and change `data` to 8'hFF and `left` → transmitted bits and `en_out` count unchanged; no extra frame is sent.
- Corner CLKS_PER_BIT=1, WIDTH=2: `data`=2'b10, `left`=1 → `serial` sequence 0,1,0,1. `en_out` high on cycles 2–3 and `done` on cycle 4 after accept.

Source files
------------

// File: rtl/serial_transmitter.sv
// serial_transmitter
// Parallel-in, serial-out framed transmitter. A WIDTH-bit word is accepted
// over a valid/ready handshake and sent as one start bit (0), WIDTH data
// bits and one stop bit (1), each bit held for CLKS_PER_BIT clocks.
// Bit order is chosen per word with 'left' (1 = MSB first).
//
// Ports:
//   clock   - sole clock, rising edge
//   reset   - asynchronous, active-high reset
//   data    - word to transmit, sampled at accept
//   valid   - data/left are offered
//   left    - bit order, sampled at accept
//   ready   - transmitter can accept a word this cycle (idle)
//   serial  - line output, idles high
//   busy    - frame in progress
//   en_out  - strobe in the last cycle of each data bit (receiver capture)
//   done    - pulse in the last cycle of the stop bit
module serial_transmitter #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  input  logic             left,
  output logic             ready,
  output logic             serial,
  output logic             busy,
  output logic             en_out,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cyc_cnt, cyc_next;
  logic [BW-1:0]    bit_cnt, bit_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic             left_q, left_next;
  logic             serial_q, serial_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             bit_end;

  // State, counters, shift register and the registered line outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      left_q   <= 1'b0;
      serial_q <= 1'b1;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_next;
      cyc_cnt  <= cyc_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      left_q   <= left_next;
      serial_q <= serial_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. The line outputs are decoded from the next-state
  // values so that once registered they line up with the state they
  // describe, rather than lagging it by a cycle.
  always_comb begin
    state_next = state;
    cyc_next   = cyc_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    left_next  = left_q;
    serial_d   = 1'b1;
    en_d       = 1'b0;
    done_d     = 1'b0;
    bit_end    = (cyc_cnt == CYC_LAST);

    case (state)
      IDLE: begin
        if (valid) begin
          shreg_next = data;
          left_next  = left;
          cyc_next   = '0;
          bit_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          cyc_next   = '0;
          state_next = DATA;
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_next = '0;
          if (bit_cnt == BIT_LAST) begin
            state_next = STOP;
          end else begin
            bit_next   = bit_cnt + 1'b1;
            // The transmitted bit always sits at the end selected by
            // left, so shifting toward that end exposes the next one.
            shreg_next = left_q ? (shreg << 1) : (shreg >> 1);
          end
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cyc_next   = '0;
          state_next = IDLE;
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START: serial_d = 1'b0;
      DATA: begin
        serial_d = left_next ? shreg_next[WIDTH-1] : shreg_next[0];
        en_d     = (cyc_next == CYC_LAST);
      end
      STOP: begin
        serial_d = 1'b1;
        done_d   = (cyc_next == CYC_LAST);
      end
      default: serial_d = 1'b1;
    endcase
  end

  assign ready  = (state == IDLE);
  assign busy   = ~ready;
  assign serial = serial_q;
  assign en_out = en_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter
// Self-checking bench for serial_transmitter. One instance uses the
// default WIDTH=8, CLKS_PER_BIT=4; a second uses WIDTH=2, CLKS_PER_BIT=1
// for the single-clock-per-bit corner. Frames are checked against
// hand-computed bit patterns and a behavioural loopback receiver.
module tb_serial_transmitter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       left  = 1'b0;
  logic       ready, serial, busy, en_out, done;

  logic [1:0] data2  = 2'b00;
  logic       valid2 = 1'b0;
  logic       left2  = 1'b0;
  logic       ready2, serial2, busy2, en_out2, done2;

  int vecCount  = 0;
  int failCount = 0;

  typedef struct {
    logic [7:0] data;
    logic       left;
    logic [9:0] expBits;
    logic [7:0] expWord;
    bit         disturb;
  } vec_t;

  vec_t vecs[5];

  serial_transmitter #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .data   (data),
    .valid  (valid),
    .left   (left),
    .ready  (ready),
    .serial (serial),
    .busy   (busy),
    .en_out (en_out),
    .done   (done)
  );

  serial_transmitter #(.WIDTH(2), .CLKS_PER_BIT(1)) dut2 (
    .clock  (clock),
    .reset  (reset),
    .data   (data2),
    .valid  (valid2),
    .left   (left2),
    .ready  (ready2),
    .serial (serial2),
    .busy   (busy2),
    .en_out (en_out2),
    .done   (done2)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Wait (bounded) for ready, offer one word, and return at #1 after the
  // accept edge, i.e. in the first cycle of the frame.
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int waited = 0;
    while (ready !== 1'b1 && waited < 200) begin
      @(posedge clock);
      #1;
      waited++;
    end
    checkOutput("ready_before_accept", ready, 1'b1);
    data  = d;
    left  = l;
    valid = 1'b1;
    @(posedge clock);
    #1;
    valid = 1'b0;
  endtask

  // Observe one 40-cycle frame starting in cycle 1 after accept, then
  // check the idle cycle that follows.
  task automatic monitorFrame(input string tag, input logic [9:0] expBits,
                              input logic [7:0] expWord, input logic lft,
                              input bit disturb);
    int bitBad[10];
    int enGood = 0, enBad = 0, doneGood = 0, doneBad = 0, readyBad = 0;
    int bi, pos;
    logic [7:0] rx = 8'h00;
    for (int i = 0; i < 10; i++) bitBad[i] = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin
        @(posedge clock);
        #1;
      end
      bi  = (k - 1) / 4;
      pos = (k - 1) % 4;
      if (serial !== expBits[9-bi]) bitBad[bi]++;
      if (en_out === 1'b1) begin
        if (bi >= 1 && bi <= 8 && pos == 3) enGood++;
        else enBad++;
        rx = lft ? {rx[6:0], serial} : {serial, rx[7:1]};
      end
      if (done === 1'b1) begin
        if (k == 40) doneGood++;
        else doneBad++;
      end
      if (ready !== 1'b0 || busy !== 1'b1) readyBad++;
      if (disturb) begin
        if (k == 8) begin
          valid = 1'b1;
          data  = 8'hFF;
          left  = ~lft;
        end
        if (k == 30) valid = 1'b0;
      end
    end
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("%s_bit%0d_errs", tag, i), bitBad[i], 0);
    checkOutput({tag, "_en_good"}, enGood, 8);
    checkOutput({tag, "_en_stray"}, enBad, 0);
    checkOutput({tag, "_done_at40"}, doneGood, 1);
    checkOutput({tag, "_done_stray"}, doneBad, 0);
    checkOutput({tag, "_busy_cycles_bad"}, readyBad, 0);
    checkOutput({tag, "_rx_word"}, rx, expWord);
    @(posedge clock);
    #1;
    checkOutput({tag, "_idle_ready"}, ready, 1'b1);
    checkOutput({tag, "_idle_serial"}, serial, 1'b1);
    checkOutput({tag, "_idle_done"}, done, 1'b0);
  endtask

  initial begin
    logic [3:0] expSer, expEn, expDone;

    vecs[0] = '{8'hC1, 1'b1, 10'b0_11000001_1, 8'hC1, 1'b0};
    vecs[1] = '{8'hC1, 1'b0, 10'b0_10000011_1, 8'hC1, 1'b0};
    vecs[2] = '{8'hA7, 1'b0, 10'b0_11100101_1, 8'hA7, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 10'b0_01011010_1, 8'h5A, 1'b0};
    vecs[4] = '{8'h3B, 1'b0, 10'b0_11011100_1, 8'h3B, 1'b1};

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_ready", ready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_serial", serial, 1'b1);
    checkOutput("rst_en_out", en_out, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    reset = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].data, vecs[v].left);
      monitorFrame($sformatf("vec%0d", v), vecs[v].expBits, vecs[v].expWord,
                   vecs[v].left, vecs[v].disturb);
    end
    // No extra frame after the disturbed one.
    @(posedge clock);
    #1;
    checkOutput("no_extra_frame_ready", ready, 1'b1);

    // Back-to-back with valid held high.
    data  = 8'h12;
    left  = 1'b1;
    valid = 1'b1;
    @(posedge clock);
    #1;
    monitorFrame("b2b_first", 10'b0_00010010_1, 8'h12, 1'b1, 1'b0);
    data = 8'h34;
    @(posedge clock);
    #1;
    valid = 1'b0;
    monitorFrame("b2b_second", 10'b0_00110100_1, 8'h34, 1'b1, 1'b0);

    // Reset while idle, checked before any clock edge.
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("rst_idle_ready", ready, 1'b1);
    checkOutput("rst_idle_serial", serial, 1'b1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset in the middle of DATA: cycle 16 carries a 0 bit with en_out high.
    applyStimulus(8'hC1, 1'b1);
    repeat (15) @(posedge clock);
    #1;
    checkOutput("pre_rst_en_out", en_out, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_serial", serial, 1'b1);
    checkOutput("rst_mid_ready", ready, 1'b1);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_en_out", en_out, 1'b0);
    checkOutput("rst_mid_done", done, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(8'h5A, 1'b1);
    monitorFrame("post_rst", 10'b0_01011010_1, 8'h5A, 1'b1, 1'b0);

    // Reset held across an edge with valid high: nothing is accepted.
    #1;
    data  = 8'hFF;
    left  = 1'b1;
    valid = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rst_vs_accept_ready", ready, 1'b1);
    valid = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rst_vs_accept_idle", ready, 1'b1);
    checkOutput("rst_vs_accept_serial", serial, 1'b1);

    // WIDTH=2, CLKS_PER_BIT=1 corner: data 2'b10 MSB first.
    expSer  = 4'b0101;
    expEn   = 4'b0110;
    expDone = 4'b0001;
    checkOutput("c1_ready_before", ready2, 1'b1);
    data2  = 2'b10;
    left2  = 1'b1;
    valid2 = 1'b1;
    @(posedge clock);
    #1;
    valid2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin
        @(posedge clock);
        #1;
      end
      checkOutput($sformatf("c1_serial_cyc%0d", k), serial2, expSer[4-k]);
      checkOutput($sformatf("c1_en_cyc%0d", k), en_out2, expEn[4-k]);
      checkOutput($sformatf("c1_done_cyc%0d", k), done2, expDone[4-k]);
      checkOutput($sformatf("c1_busy_cyc%0d", k), busy2, 1'b1);
    end
    @(posedge clock);
    #1;
    checkOutput("c1_ready_after", ready2, 1'b1);
    checkOutput("c1_serial_after", serial2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
